// File: rtl/xor_gate.sv
// Single-bit XOR built from four 2-input NAND primitives, plus a registered copy
// of the result and a saturating count of cycles in which the inputs differed.
module xor_gate #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inA,
  input  logic             inB,
  output logic             out,
  output logic             outQ,
  output logic [CNT_W-1:0] diffCount
);

  logic n_ab;
  logic n_a;
  logic n_b;

  // Classic four-NAND XOR; no clock or reset on this path.
  nand u_nand_ab  (n_ab, inA, inB);
  nand u_nand_a   (n_a,  inA, n_ab);
  nand u_nand_b   (n_b,  inB, n_ab);
  nand u_nand_out (out,  n_a, n_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      outQ      <= 1'b0;
      diffCount <= '0;
    end else begin
      outQ <= out;
      // Saturate at all-ones rather than wrapping.
      if (out && (diffCount != '1)) begin
        diffCount <= diffCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: directed scenarios plus randomized traffic
// compared against a simple arithmetic model of the registered outputs.
module tb_xor_gate;

  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          inA;
  logic          inB;
  logic          out;
  logic          outQ;
  logic [CW-1:0] diffCount;

  bit clk_en;
  int checks;
  int failures;

  // Reference state: what outQ and diffCount should hold after the last edge.
  int exp_q;
  int exp_cnt;

  xor_gate #(.CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .inA       (inA),
    .inB       (inB),
    .out       (out),
    .outQ      (outQ),
    .diffCount (diffCount)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  function automatic int ref_xor(input int a, input int b);
    return ((a + b) == 1) ? 1 : 0;
  endfunction

  // Drive inputs after a falling edge, take one rising edge, update the model, settle.
  task automatic step(input logic a, input logic b, input logic r);
    @(negedge clk);
    inA   = a;
    inB   = b;
    reset = r;
    @(posedge clk);
    if (r) begin
      exp_q   = 0;
      exp_cnt = 0;
    end else begin
      exp_q   = ref_xor(int'(a), int'(b));
      exp_cnt = (exp_cnt + exp_q > MAXV) ? MAXV : exp_cnt + exp_q;
    end
    #1;
  endtask

  task automatic test_comb;
    logic [1:0] pat;
    logic       exp;
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      inA = pat[1];
      inB = pat[0];
      #1;
      exp = ref_xor(int'(pat[1]), int'(pat[0])) != 0;
      checks++;
      if (out !== exp) begin
        failures++;
        $display("FAIL comb_%0d%0d out=%b expected=%b", pat[1], pat[0], out, exp);
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (outQ !== 1'b0 || diffCount !== '0 || out !== 1'b1) begin
        failures++;
        $display("FAIL reset_edge%0d outQ=%b diffCount=%0d out=%b expected outQ=0 diffCount=0 out=1",
                 i, outQ, diffCount, out);
      end
    end
  endtask

  task automatic test_latency;
    logic [1:0] seq [4];
    logic [3:0] exp_q_seq;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    exp_q_seq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(seq[i][1], seq[i][0], 1'b0);
      checks++;
      if (outQ !== exp_q_seq[3-i]) begin
        failures++;
        $display("FAIL latency_outQ_%0d outQ=%b expected=%b", i, outQ, exp_q_seq[3-i]);
      end
    end
    checks++;
    if (diffCount !== 4'd2) begin
      failures++;
      $display("FAIL latency_count diffCount=%0d expected=2", diffCount);
    end
  endtask

  task automatic test_saturation;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i >= MAXV) begin
        checks++;
        if (diffCount !== 4'(MAXV)) begin
          failures++;
          $display("FAIL saturation_edge%0d diffCount=%0d expected=%0d", i, diffCount, MAXV);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (diffCount !== 4'd5) begin
      failures++;
      $display("FAIL midreset_pre diffCount=%0d expected=5", diffCount);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (diffCount !== 4'd0 || outQ !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear diffCount=%0d outQ=%b expected 0 0", diffCount, outQ);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (diffCount !== 4'd1 || outQ !== 1'b1) begin
      failures++;
      $display("FAIL midreset_resume diffCount=%0d outQ=%b expected 1 1", diffCount, outQ);
    end
  endtask

  task automatic test_glitch;
    logic [CW-1:0] cnt_before;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    cnt_before = diffCount;
    @(negedge clk);
    reset = 1'b0;
    inA   = 1'b0;
    inB   = 1'b0;
    #1;
    inB = 1'b1;
    #1;
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("FAIL glitch_high out=%b expected=1", out);
    end
    inB = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL glitch_low out=%b expected=0", out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (outQ !== 1'b0 || diffCount !== cnt_before || cnt_before !== 4'd1) begin
      failures++;
      $display("FAIL glitch_sample outQ=%b diffCount=%0d expected outQ=0 diffCount=1",
               outQ, diffCount);
    end
    exp_q   = 0;
    exp_cnt = 1;
  endtask

  task automatic test_random;
    logic a, b, r;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      a = 1'($urandom);
      b = 1'($urandom);
      r = ($urandom_range(0, 39) == 0);
      step(a, b, r);
      checks++;
      if (out !== (ref_xor(int'(a), int'(b)) != 0) || outQ !== (exp_q != 0) ||
          diffCount !== exp_cnt[CW-1:0]) begin
        failures++;
        $display("FAIL random_%0d a=%b b=%b r=%b out=%b outQ=%b diffCount=%0d expected outQ=%0d diffCount=%0d",
                 i, a, b, r, out, outQ, diffCount, exp_q, exp_cnt);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_q    = 0;
    exp_cnt  = 0;
    clk_en   = 1'b0;
    test_comb();
    clk    = 1'b0;
    reset  = 1'b0;
    clk_en = 1'b1;
    test_reset();
    test_latency();
    test_saturation();
    test_mid_reset();
    test_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
